// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_stage_params / wb_stage_params
// Brief    : Bus types and CP0/ExcCode constants shared by the write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
package io_stage_params;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] final_result;
        logic        register_file_write_enabled;
        logic [3:0]  register_file_write_strobe;
        logic [4:0]  write_register;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic        is_address_fault;
        logic [31:0] badvaddr_value;
        logic        is_delay_slot;
        logic        eret;
        logic        move_from_cp0;
        logic        move_to_cp0;
        logic [4:0]  cp0_address_register;
        logic [2:0]  cp0_address_select;
        logic        tlb_probe;
        logic        tlb_read;
        logic        tlb_write;
    } io_to_wb_bus_t;

endpackage

package wb_stage_params;

    typedef struct packed {
        logic        exception_valid;
        logic        eret_flush;
        logic [31:0] redirect_pc;
    } wb_exception_bus_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [3:0]  write_strobe;
        logic [31:0] write_data;
    } wb_to_id_back_pass_bus_t;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [2:0] CP0_SELECT_0 = 3'd0;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage
`default_nettype wire

// File: rtl/wb_stage_cp0_register_file.sv
`default_nettype none
// ============================================================================
// Module   : cp0_register_file
// Brief    : CP0 Status/Cause/EPC/BadVAddr/Count/Compare state and timer.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_register_file
    import wb_stage_params::*;
#(
    parameter int COUNT_TICK_DIVIDE = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  hardware_interrupt,
    input  logic        write_enable,
    input  logic [4:0]  address_register,
    input  logic [2:0]  address_select,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        exception_commit,
    input  logic [4:0]  exception_code,
    input  logic        is_delay_slot,
    input  logic [31:0] exception_pc,
    input  logic        address_fault,
    input  logic [31:0] badvaddr_value,
    input  logic        eret_commit,
    output logic [31:0] epc,
    output logic        interrupt_pending
);

    localparam int c_tick_width = (COUNT_TICK_DIVIDE > 1) ? $clog2(COUNT_TICK_DIVIDE) : 1;
    localparam logic [c_tick_width-1:0] c_tick_last = c_tick_width'(COUNT_TICK_DIVIDE - 1);

    logic [7:0]              r_status_im;
    logic                    r_status_exl;
    logic                    r_status_ie;
    logic                    r_cause_bd;
    logic                    r_cause_ti;
    logic [5:0]              r_cause_ip_hw;
    logic [1:0]              r_cause_ip_sw;
    logic [4:0]              r_cause_exccode;
    logic [31:0]             r_epc;
    logic [31:0]             r_badvaddr;
    logic [31:0]             r_count;
    logic [31:0]             r_compare;
    logic [c_tick_width-1:0] r_tick_count;

    logic w_select_0, w_write_status, w_write_cause, w_write_count, w_write_compare, w_tick;
    logic [31:0] w_status, w_cause;

    assign w_select_0      = (address_select == CP0_SELECT_0);
    assign w_write_status  = write_enable & w_select_0 & (address_register == CP0_STATUS);
    assign w_write_cause   = write_enable & w_select_0 & (address_register == CP0_CAUSE);
    assign w_write_count   = write_enable & w_select_0 & (address_register == CP0_COUNT);
    assign w_write_compare = write_enable & w_select_0 & (address_register == CP0_COMPARE);
    assign w_tick          = (r_tick_count == c_tick_last);

    // BEV (bit 22) is hard-wired to 1; only IM, EXL and IE hold state.
    assign w_status = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, r_cause_ti, 14'b0, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exccode, 2'b0};

    assign epc               = r_epc;
    assign interrupt_pending = r_status_ie & ~r_status_exl &
                               (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_status_im  <= 8'h00;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else begin
            if (w_write_status) begin
                r_status_im  <= write_data[15:8];
                r_status_exl <= write_data[1];
                r_status_ie  <= write_data[0];
            end
            if (exception_commit) begin
                r_status_exl <= 1'b1;
            end else if (eret_commit) begin
                r_status_exl <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cause_bd      <= 1'b0;
            r_cause_ti      <= 1'b0;
            r_cause_ip_hw   <= 6'h00;
            r_cause_ip_sw   <= 2'b00;
            r_cause_exccode <= 5'h00;
            r_epc           <= 32'h0;
            r_badvaddr      <= 32'h0;
        end else begin
            r_cause_ip_hw <= {r_cause_ti | hardware_interrupt[5], hardware_interrupt[4:0]};
            if (w_write_cause) begin
                r_cause_ip_sw <= write_data[9:8];
            end
            // Writing Compare acknowledges the timer even on a same-cycle match.
            if (w_write_compare) begin
                r_cause_ti <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != 32'h0)) begin
                r_cause_ti <= 1'b1;
            end
            if (exception_commit) begin
                r_cause_exccode <= exception_code;
                if (!r_status_exl) begin
                    r_cause_bd <= is_delay_slot;
                    r_epc      <= is_delay_slot ? exception_pc - 32'd4 : exception_pc;
                end
                if (address_fault) begin
                    r_badvaddr <= badvaddr_value;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count      <= 32'h0;
            r_compare    <= 32'h0;
            r_tick_count <= '0;
        end else begin
            if (w_write_compare) begin
                r_compare <= write_data;
            end
            if (w_write_count) begin
                r_count      <= write_data;
                r_tick_count <= '0;
            end else begin
                r_tick_count <= w_tick ? '0 : r_tick_count + 1'b1;
                if (w_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (w_select_0) begin
            case (address_register)
                CP0_BADVADDR: read_data = r_badvaddr;
                CP0_COUNT:    read_data = r_count;
                CP0_COMPARE:  read_data = r_compare;
                CP0_STATUS:   read_data = w_status;
                CP0_CAUSE:    read_data = w_cause;
                CP0_EPC:      read_data = r_epc;
                default:      read_data = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Write-back stage: GPR retire, exception/eret redirect, CP0 access.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import io_stage_params::*;
    import wb_stage_params::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY   = 32'hBFC0_0380,
    parameter int          COUNT_TICK_DIVIDE = 2
)(
    input  logic                    clock,
    input  logic                    reset,
    input  io_to_wb_bus_t           io_to_wb_bus,
    output logic                    wb_allow_in,
    input  logic [5:0]              hardware_interrupt,
    output logic [3:0]              register_file_write_strobe,
    output logic [4:0]              register_file_write_address,
    output logic [31:0]             register_file_write_data,
    output wb_to_id_back_pass_bus_t wb_to_id_back_pass_bus,
    output wb_exception_bus_t       wb_exception_bus,
    output logic                    io_have_exception_backwards,
    output logic                    interrupt_pending
);

    logic          r_valid;
    io_to_wb_bus_t r_bus;

    logic        w_interrupt_taken, w_exception, w_eret, w_mtc0_write, w_gpr_write;
    logic [31:0] w_cp0_read_data, w_epc;
    logic [4:0]  w_exception_code;
    logic        w_unused_bus;

    assign wb_allow_in = 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else begin
            r_valid <= io_to_wb_bus.valid;
            if (io_to_wb_bus.valid && wb_allow_in) begin
                r_bus <= io_to_wb_bus;
            end
        end
    end

    // TLB operations have no state here and simply retire.
    assign w_unused_bus = ^{r_bus.valid, r_bus.tlb_probe, r_bus.tlb_read, r_bus.tlb_write};

    assign w_interrupt_taken = r_valid & interrupt_pending & ~r_bus.exception_valid &
                               ~r_bus.eret & ~r_bus.move_to_cp0;
    assign w_exception       = (r_valid & r_bus.exception_valid) | w_interrupt_taken;
    assign w_eret            = r_valid & r_bus.eret & ~r_bus.exception_valid;
    assign w_mtc0_write      = r_valid & r_bus.move_to_cp0 & ~r_bus.exception_valid;
    assign w_gpr_write       = r_valid & ~w_exception & ~w_eret &
                               (r_bus.register_file_write_enabled | r_bus.move_from_cp0);
    assign w_exception_code  = w_interrupt_taken ? EXC_INT : r_bus.exception_code;

    cp0_register_file #(
        .COUNT_TICK_DIVIDE (COUNT_TICK_DIVIDE)
    ) u_cp0 (
        .clock              (clock),
        .reset              (reset),
        .hardware_interrupt (hardware_interrupt),
        .write_enable       (w_mtc0_write),
        .address_register   (r_bus.cp0_address_register),
        .address_select     (r_bus.cp0_address_select),
        .write_data         (r_bus.final_result),
        .read_data          (w_cp0_read_data),
        .exception_commit   (w_exception),
        .exception_code     (w_exception_code),
        .is_delay_slot      (r_bus.is_delay_slot),
        .exception_pc       (r_bus.pc),
        .address_fault      (r_bus.exception_valid & r_bus.is_address_fault),
        .badvaddr_value     (r_bus.badvaddr_value),
        .eret_commit        (w_eret),
        .epc                (w_epc),
        .interrupt_pending  (interrupt_pending)
    );

    assign register_file_write_strobe  = !w_gpr_write          ? 4'h0 :
                                         r_bus.move_from_cp0   ? 4'hF :
                                                                 r_bus.register_file_write_strobe;
    assign register_file_write_address = r_bus.write_register;
    assign register_file_write_data    = r_bus.move_from_cp0 ? w_cp0_read_data : r_bus.final_result;

    assign wb_to_id_back_pass_bus.valid          = w_gpr_write;
    assign wb_to_id_back_pass_bus.write_register = register_file_write_address;
    assign wb_to_id_back_pass_bus.write_strobe   = register_file_write_strobe;
    assign wb_to_id_back_pass_bus.write_data     = register_file_write_data;

    assign wb_exception_bus.exception_valid = w_exception;
    assign wb_exception_bus.eret_flush      = w_eret;
    assign wb_exception_bus.redirect_pc     = w_exception ? EXCEPTION_ENTRY :
                                              w_eret      ? w_epc : 32'h0;

    assign io_have_exception_backwards = r_valid & (w_exception | w_eret | w_interrupt_taken);

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage against a CP0 reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import io_stage_params::*;
    import wb_stage_params::*;

    localparam logic [31:0] ENTRY = 32'hBFC0_0380;
    localparam int          DIV   = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    io_to_wb_bus_t           io_to_wb_bus = '0;
    logic                    wb_allow_in;
    logic [5:0]              hardware_interrupt = 6'h0;
    logic [3:0]              register_file_write_strobe;
    logic [4:0]              register_file_write_address;
    logic [31:0]             register_file_write_data;
    wb_to_id_back_pass_bus_t wb_to_id_back_pass_bus;
    wb_exception_bus_t       wb_exception_bus;
    logic                    io_have_exception_backwards;
    logic                    interrupt_pending;

    wb_stage #(.EXCEPTION_ENTRY(ENTRY), .COUNT_TICK_DIVIDE(DIV)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_to_wb_bus                (io_to_wb_bus),
        .wb_allow_in                 (wb_allow_in),
        .hardware_interrupt          (hardware_interrupt),
        .register_file_write_strobe  (register_file_write_strobe),
        .register_file_write_address (register_file_write_address),
        .register_file_write_data    (register_file_write_data),
        .wb_to_id_back_pass_bus      (wb_to_id_back_pass_bus),
        .wb_exception_bus            (wb_exception_bus),
        .io_have_exception_backwards (io_have_exception_backwards),
        .interrupt_pending           (interrupt_pending)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural reference state
    logic [31:0] m_status, m_epc, m_badv, m_compare, m_count_base;
    logic        m_bd, m_ti;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exccode;
    int          m_count_cyc;
    logic [31:0] last_data;

    task automatic model_reset();
        m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_compare = 0;
        m_bd = 0; m_ti = 0; m_ip_sw = 0; m_exccode = 0;
        m_count_base = 0; m_count_cyc = cyc;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s, input logic [5:0] hw);
        logic [7:0] ip;
        ip = {m_ti | hw[5], hw[4:0], m_ip_sw};
        if (s != 3'd0) return 32'h0;
        case (r)
            5'd8:    return m_badv;
            5'd9:    return m_count_base + 32'((cyc - m_count_cyc) / DIV);
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, m_ti, 14'b0, ip, 1'b0, m_exccode, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one instruction, check the retire cycle, then advance the model.
    task automatic retire(input io_to_wb_bus_t b, input logic [5:0] hw);
        logic [7:0]  ip;
        logic        pend, intr, exc, ert, wr;
        logic [3:0]  strobe;
        logic [31:0] redirect, data;
        @(negedge clock);
        b.valid = 1'b1;
        io_to_wb_bus = b;
        hardware_interrupt = hw;
        @(negedge clock);
        ip       = {m_ti | hw[5], hw[4:0], m_ip_sw};
        pend     = m_status[0] & ~m_status[1] & (|(ip & m_status[15:8]));
        intr     = pend & ~b.exception_valid & ~b.eret & ~b.move_to_cp0;
        exc      = b.exception_valid | intr;
        ert      = b.eret & ~b.exception_valid;
        redirect = exc ? ENTRY : (ert ? m_epc : 32'h0);
        wr       = !exc && !ert && (b.register_file_write_enabled || b.move_from_cp0);
        strobe   = !wr ? 4'h0 : (b.move_from_cp0 ? 4'hF : b.register_file_write_strobe);
        data     = b.move_from_cp0 ? m_read(b.cp0_address_register, b.cp0_address_select, hw)
                                   : b.final_result;
        last_data = register_file_write_data;
        check("int_pending", 32'(interrupt_pending), 32'(pend));
        check("exc_valid", 32'(wb_exception_bus.exception_valid), 32'(exc));
        check("eret_flush", 32'(wb_exception_bus.eret_flush), 32'(ert));
        check("redirect", wb_exception_bus.redirect_pc, redirect);
        check("backwards", 32'(io_have_exception_backwards), 32'(exc | ert));
        check("rf_strobe", 32'(register_file_write_strobe), 32'(strobe));
        check("rf_addr", 32'(register_file_write_address), 32'(b.write_register));
        check("bp_valid", 32'(wb_to_id_back_pass_bus.valid), 32'(wr));
        check("bp_strobe", 32'(wb_to_id_back_pass_bus.write_strobe), 32'(strobe));
        if (wr) begin
            check("rf_data", register_file_write_data, data);
            check("bp_data", wb_to_id_back_pass_bus.write_data, data);
        end
        io_to_wb_bus = '0;
        if (exc) begin
            if (!m_status[1]) begin
                m_epc = b.is_delay_slot ? b.pc - 32'd4 : b.pc;
                m_bd  = b.is_delay_slot;
            end
            m_exccode = intr ? 5'd0 : b.exception_code;
            if (b.exception_valid && b.is_address_fault) m_badv = b.badvaddr_value;
            m_status[1] = 1'b1;
        end else if (ert) begin
            m_status[1] = 1'b0;
        end else if (b.move_to_cp0 && b.cp0_address_select == 3'd0) begin
            case (b.cp0_address_register)
                5'd9:  begin m_count_base = b.final_result; m_count_cyc = cyc + 1; end
                5'd11: begin m_compare = b.final_result; m_ti = 1'b0; end
                5'd12: m_status = (m_status & ~32'h0000_FF03) | (b.final_result & 32'h0000_FF03);
                5'd13: m_ip_sw = b.final_result[9:8];
                default: ;
            endcase
        end
    endtask

    function automatic io_to_wb_bus_t mk_alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        io_to_wb_bus_t b = '0;
        b.pc = pc; b.write_register = rd; b.final_result = d;
        b.register_file_write_enabled = 1'b1; b.register_file_write_strobe = 4'hF;
        return b;
    endfunction

    function automatic io_to_wb_bus_t mk_cp0(input logic to_cp0, input logic [4:0] r, input logic [31:0] d);
        io_to_wb_bus_t b = '0;
        b.pc = 32'h0000_0100; b.write_register = 5'd2; b.final_result = d;
        b.move_to_cp0 = to_cp0; b.move_from_cp0 = ~to_cp0; b.cp0_address_register = r;
        return b;
    endfunction

    function automatic io_to_wb_bus_t mk_exc(input logic [31:0] pc, input logic [4:0] code,
                                             input logic ds, input logic [31:0] badv);
        io_to_wb_bus_t b = mk_alu(pc, 5'd7, 32'hDEAD_BEEF);
        b.exception_valid = 1'b1; b.exception_code = code; b.is_delay_slot = ds;
        b.is_address_fault = (code == 5'd4) || (code == 5'd5); b.badvaddr_value = badv;
        return b;
    endfunction

    function automatic io_to_wb_bus_t mk_eret();
        io_to_wb_bus_t b = '0;
        b.pc = 32'h0000_0200; b.eret = 1'b1;
        return b;
    endfunction

    io_to_wb_bus_t b;

    initial begin
        #1;
        check("reset_strobe", 32'(register_file_write_strobe), 32'h0);
        check("reset_exc", 32'(wb_exception_bus.exception_valid), 32'h0);
        check("allow_in", 32'(wb_allow_in), 32'h1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Plain ALU retire
        retire(mk_alu(32'h1000, 5'd5, 32'h1234), 6'h0);

        // lw AdEL
        retire(mk_exc(32'h2000, 5'd4, 1'b0, 32'h3), 6'h0);
        retire(mk_cp0(1'b0, 5'd14, 0), 6'h0);
        check("adel_epc", last_data, 32'h2000);
        retire(mk_cp0(1'b0, 5'd13, 0), 6'h0);
        check("adel_exccode", 32'(last_data[6:2]), 32'd4);
        retire(mk_cp0(1'b0, 5'd8, 0), 6'h0);
        check("adel_badvaddr", last_data, 32'h3);
        retire(mk_eret(), 6'h0);

        // Delay slot exception, then nested exception with EXL set
        retire(mk_exc(32'h2004, 5'd10, 1'b1, 0), 6'h0);
        retire(mk_cp0(1'b0, 5'd14, 0), 6'h0);
        check("ds_epc", last_data, 32'h2000);
        retire(mk_cp0(1'b0, 5'd13, 0), 6'h0);
        check("ds_bd", 32'(last_data[31]), 32'h1);
        retire(mk_exc(32'h3008, 5'd12, 1'b0, 0), 6'h0);
        retire(mk_cp0(1'b0, 5'd14, 0), 6'h0);
        check("exl_epc_kept", last_data, 32'h2000);
        retire(mk_cp0(1'b0, 5'd13, 0), 6'h0);
        check("exl_bd_kept", 32'(last_data[31]), 32'h1);
        check("exl_exccode", 32'(last_data[6:2]), 32'd12);
        retire(mk_eret(), 6'h0);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [4:0] regs [6];
            regs = '{5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd3};
            kind = int'($urandom_range(0, 9));
            b = '0;
            b.pc = $urandom & 32'hFFFF_FFFC;
            b.final_result = $urandom;
            b.write_register = 5'($urandom);
            b.register_file_write_strobe = 4'($urandom);
            b.register_file_write_enabled = 1'($urandom);
            b.is_delay_slot = 1'($urandom);
            case (kind)
                4: begin
                    b.move_from_cp0 = 1'b1;
                    b.cp0_address_register = regs[$urandom_range(0, 5)];
                    b.cp0_address_select = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
                end
                5: begin
                    b.move_to_cp0 = 1'b1;
                    b.register_file_write_enabled = 1'b0;
                    b.cp0_address_register = regs[$urandom_range(0, 4) == 1 ? 0 : $urandom_range(2, 4)];
                end
                6: begin
                    b.exception_valid = 1'b1;
                    b.exception_code = 5'($urandom_range(4, 12));
                    b.is_address_fault = 1'($urandom);
                    b.badvaddr_value = $urandom;
                end
                7: b.eret = 1'b1;
                8: begin
                    b.tlb_probe = 1'($urandom); b.tlb_read = 1'($urandom); b.tlb_write = 1'($urandom);
                end
                default: ;
            endcase
            retire(b, ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'h0);
        end

        // Timer interrupt
        retire(mk_cp0(1'b1, 5'd13, 32'h0), 6'h0);
        retire(mk_cp0(1'b1, 5'd12, 32'h0000_8001), 6'h0);
        retire(mk_cp0(1'b1, 5'd11, 32'd10), 6'h0);
        retire(mk_cp0(1'b1, 5'd9, 32'd0), 6'h0);
        repeat (15) @(negedge clock);
        check("timer_early", 32'(interrupt_pending), 32'h0);
        repeat (9) @(negedge clock);
        check("timer_fired", 32'(interrupt_pending), 32'h1);
        m_ti = 1'b1;
        retire(mk_alu(32'h5000, 5'd9, 32'h55), 6'h0);
        retire(mk_cp0(1'b0, 5'd13, 0), 6'h0);
        check("timer_ti", 32'(last_data[30]), 32'h1);
        check("timer_exccode", 32'(last_data[6:2]), 32'd0);
        retire(mk_cp0(1'b1, 5'd11, 32'd0), 6'h0);
        retire(mk_eret(), 6'h0);

        // eret to EPC 0x4000, then Count wrap
        retire(mk_exc(32'h4000, 5'd8, 1'b0, 0), 6'h0);
        retire(mk_eret(), 6'h0);
        retire(mk_cp0(1'b0, 5'd12, 0), 6'h0);
        check("eret_status", last_data, 32'h0040_8001);
        retire(mk_cp0(1'b1, 5'd9, 32'hFFFF_FFFF), 6'h0);
        retire(mk_cp0(1'b0, 5'd9, 0), 6'h0);
        check("count_max", last_data, 32'hFFFF_FFFF);
        retire(mk_cp0(1'b0, 5'd9, 0), 6'h0);
        check("count_wrap", last_data, 32'h0);

        // Asynchronous reset in the middle of an exception retire
        @(negedge clock);
        b = mk_exc(32'h6000, 5'd4, 1'b0, 32'h11);
        b.valid = 1'b1;
        io_to_wb_bus = b;
        @(negedge clock);
        check("pre_reset_exc", 32'(wb_exception_bus.exception_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_exc", 32'(wb_exception_bus.exception_valid), 32'h0);
        check("rst_eret", 32'(wb_exception_bus.eret_flush), 32'h0);
        check("rst_redirect", wb_exception_bus.redirect_pc, 32'h0);
        check("rst_backwards", 32'(io_have_exception_backwards), 32'h0);
        check("rst_strobe", 32'(register_file_write_strobe), 32'h0);
        check("rst_bp_valid", 32'(wb_to_id_back_pass_bus.valid), 32'h0);
        check("rst_pending", 32'(interrupt_pending), 32'h0);
        io_to_wb_bus = '0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        retire(mk_cp0(1'b0, 5'd12, 0), 6'h0);
        check("rst_status", last_data, 32'h0040_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
